// File: rtl/shift_cmd_sequencer.sv
// Command FIFO, issue register and result register wrapped around the external
// combinational arithmetic-right shifter. Optional tag sideband: SHIFT_CMD_TAG_EN.
module shift_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_num,
    input  logic [2:0]               in_amt,
`ifdef SHIFT_CMD_TAG_EN
    input  logic [1:0]               in_tag,
`endif
    output logic [7:0]               sh_num,
    output logic [2:0]               sh_shift,
    input  logic [7:0]               sh_ans,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
`ifdef SHIFT_CMD_TAG_EN
    output logic [1:0]               out_tag,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
`ifdef SHIFT_CMD_TAG_EN
        logic [1:0] tag;
`endif
        logic [7:0] num;
        logic [2:0] amt;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          s1_v_q, s1_v_d;
    cmd_t          s1_q, s1_d;
    logic          out_v_q, out_v_d;
    logic [7:0]    out_data_q, out_data_d;
`ifdef SHIFT_CMD_TAG_EN
    logic [1:0]    out_tag_q, out_tag_d;
`endif
    cmd_t          in_cmd;
    logic          push, pop, ld2, adv1;

    always_comb begin
        in_cmd     = '0;
        in_cmd.num = in_num;
        in_cmd.amt = in_amt;
`ifdef SHIFT_CMD_TAG_EN
        in_cmd.tag = in_tag;
`endif
    end

    // in_ready comes from the registered level only, so a full FIFO never
    // accepts even when the head is popped in the same cycle.
    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign ld2      = s1_v_q && (!out_v_q || out_ready);
    assign adv1     = !s1_v_q || ld2;
    assign pop      = adv1 && (level_q != '0);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        s1_v_d     = s1_v_q;
        s1_d       = s1_q;
        out_v_d    = out_v_q;
        out_data_d = out_data_q;
`ifdef SHIFT_CMD_TAG_EN
        out_tag_d  = out_tag_q;
`endif
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (adv1) begin
            s1_v_d = pop;
            if (pop) s1_d = mem_q[rptr_q];
        end
        if (ld2) begin
            out_v_d    = 1'b1;
            out_data_d = sh_ans;
`ifdef SHIFT_CMD_TAG_EN
            out_tag_d  = s1_q.tag;
`endif
        end else if (out_v_q && out_ready) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            s1_v_q     <= 1'b0;
            s1_q       <= '0;
            out_v_q    <= 1'b0;
            out_data_q <= '0;
`ifdef SHIFT_CMD_TAG_EN
            out_tag_q  <= '0;
`endif
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            s1_v_q     <= s1_v_d;
            s1_q       <= s1_d;
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
`ifdef SHIFT_CMD_TAG_EN
            out_tag_q  <= out_tag_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_cmd;
    end

    assign sh_num    = s1_q.num;
    assign sh_shift  = s1_q.amt;
    assign out_valid = out_v_q;
    assign out_data  = out_data_q;
`ifdef SHIFT_CMD_TAG_EN
    assign out_tag   = out_tag_q;
`endif
    assign level     = level_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer with a behavioural arithmetic-right shifter.
module tb_shift_cmd_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_num, sh_num, sh_ans, out_data;
    logic [2:0] in_amt, sh_shift;
    logic [2:0] level;
    logic [1:0] in_tag, out_tag;

    int nchk = 0, nerr = 0, cyc = 0;
    logic [7:0] got_d [$];
    logic [1:0] got_t [$];
    int         got_c [$];
    logic [7:0] exp4 [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sh_ans = 8'($signed(sh_num) >>> sh_shift);

    shift_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_amt(in_amt),
        .sh_num(sh_num), .sh_shift(sh_shift), .sh_ans(sh_ans),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
`ifdef SHIFT_CMD_TAG_EN
        , .in_tag(in_tag), .out_tag(out_tag)
`endif
    );

`ifndef SHIFT_CMD_TAG_EN
    assign out_tag = 2'b00;
`endif

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_t.push_back(out_tag);
            got_c.push_back(cyc);
        end
    end

    task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        got_d.delete();
        got_t.delete();
        got_c.delete();
    endtask

    task automatic send(input logic [7:0] n, input logic [2:0] a, input logic [1:0] t);
        logic rdy;
        in_valid = 1'b1;
        in_num   = n;
        in_amt   = a;
        in_tag   = t;
        for (int i = 0; i < 50; i++) begin
            rdy = in_ready;
            step();
            if (rdy) break;
            if (i == 49) chk("send_tmo", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        for (int i = 0; i < 100 && got_d.size() < n; i++) step();
        chk("res_cnt", got_d.size(), n);
    endtask

    initial begin
        logic rdy;
        int   acc;
        rst_n = 1'b0; in_valid = 1'b0; in_num = '0; in_amt = '0; in_tag = '0; out_ready = 1'b1;
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_shnum", {sh_num, 5'b0, sh_shift}, 0);
        #10 rst_n = 1'b1;
        step();

        // single command latency
        send(8'h80, 3'd1, 2'd0);
        chk("t1_lvl1", level, 1);
        chk("t1_ov0", out_valid, 0);
        step();
        chk("t1_lvl0", level, 0);
        chk("t1_shnum", sh_num, 8'h80);
        chk("t1_ov_n1", out_valid, 0);
        step();
        chk("t1_ov", out_valid, 1);
        chk("t1_data", out_data, 8'hC0);
        step();
        chk("t1_ov_drop", out_valid, 0);
        clr();

        // back-to-back stream
        send(8'h80, 3'd7, 2'd0);
        send(8'h7F, 3'd3, 2'd0);
        send(8'hF0, 3'd4, 2'd0);
        send(8'h55, 3'd0, 2'd0);
        wait_res(4);
        if (got_d.size() == 4) begin
            chk("t2_d0", got_d[0], 8'hFF);
            chk("t2_d1", got_d[1], 8'h0F);
            chk("t2_d2", got_d[2], 8'hFF);
            chk("t2_d3", got_d[3], 8'h55);
            chk("t2_gap", got_c[3] - got_c[0], 3);
        end
        clr();

        // back-pressure fill and drain
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            case (acc)
                0: begin in_num = 8'h01; in_amt = 3'd0; end
                1: begin in_num = 8'h80; in_amt = 3'd1; end
                2: begin in_num = 8'h40; in_amt = 3'd2; end
                3: begin in_num = 8'hFE; in_amt = 3'd1; end
                4: begin in_num = 8'h7F; in_amt = 3'd7; end
                default: begin in_num = 8'h90; in_amt = 3'd3; end
            endcase
            rdy = in_ready;
            step();
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        chk("t3_accepts", acc, DEPTH + 2);
        chk("t3_ready0", in_ready, 0);
        chk("t3_level", level, DEPTH);
        chk("t3_hold_v", out_valid, 1);
        chk("t3_hold_d", out_data, 8'h01);
        out_ready = 1'b1;
        wait_res(6);
        if (got_d.size() == 6) begin
            chk("t3_d0", got_d[0], 8'h01);
            chk("t3_d1", got_d[1], 8'hC0);
            chk("t3_d2", got_d[2], 8'h10);
            chk("t3_d3", got_d[3], 8'hFF);
            chk("t3_d4", got_d[4], 8'h00);
            chk("t3_d5", got_d[5], 8'hF2);
            chk("t3_gap", got_c[5] - got_c[0], 5);
        end
        clr();

        // full FIFO with toggling out_ready, 3*DEPTH commands across pointer wrap
        for (int k = 0; k < 12; k++)
            exp4[k] = 8'($signed(8'(8'h9B + k * 8'h25)) >>> (k % 8));
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 300 && acc < 12; i++) begin
            in_valid = 1'b1;
            in_num   = 8'(8'h9B + acc * 8'h25);
            in_amt   = 3'(acc % 8);
            rdy = in_ready;
            if (i % 4 == 0) chk("t4_rdy_lvl", in_ready, level != 3'(DEPTH));
            step();
            if (rdy) acc++;
            if (acc >= DEPTH + 2) out_ready = ~out_ready;
        end
        in_valid = 1'b0;
        chk("t4_accepts", acc, 12);
        out_ready = 1'b1;
        wait_res(12);
        if (got_d.size() == 12)
            for (int k = 0; k < 12; k++) chk($sformatf("t4_d%0d", k), got_d[k], exp4[k]);
        chk("t4_lvl_end", level, 0);
        clr();

        // asynchronous reset with commands in flight
        out_ready = 1'b0;
        send(8'h11, 3'd1, 2'd0);
        send(8'h22, 3'd1, 2'd0);
        send(8'h33, 3'd1, 2'd0);
        step();
        chk("t5_pre_ov", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ov", out_valid, 0);
        chk("t5_od", out_data, 0);
        chk("t5_lvl", level, 0);
        chk("t5_rdy", in_ready, 1);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        clr();
        send(8'h81, 3'd2, 2'd0);
        wait_res(1);
        if (got_d.size() == 1) chk("t5_after", got_d[0], 8'hE0);
        clr();

`ifdef SHIFT_CMD_TAG_EN
        send(8'h10, 3'd0, 2'd0);
        send(8'h20, 3'd1, 2'd1);
        send(8'h40, 3'd2, 2'd2);
        send(8'h80, 3'd3, 2'd3);
        wait_res(4);
        if (got_d.size() == 4) begin
            chk("tag_0", {got_t[0], got_d[0]}, {2'd0, 8'h10});
            chk("tag_1", {got_t[1], got_d[1]}, {2'd1, 8'h10});
            chk("tag_2", {got_t[2], got_d[2]}, {2'd2, 8'h10});
            chk("tag_3", {got_t[3], got_d[3]}, {2'd3, 8'hF0});
        end
        clr();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
